// File: rtl/ex_mem_stage_ctrl.sv
// EX/MEM pipeline slice: PC incrementer, control-word NOP mux and the
// EX/MEM register carrying store data, address, destination and mem/wb control.
module ex_mem_stage_ctrl #(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned PC_INC = 4
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [PC_W-1:0]  pc_in,
    output logic [PC_W-1:0]  pc_next,
    input  logic             nop_sel,
    input  logic [13:0]      cu_ctrl,
    output logic [13:0]      id_ctrl,
    input  logic [31:0]      ex_pd,
    input  logic [31:0]      ex_alu_res,
    input  logic [3:0]       ex_rd,
    input  logic [4:0]       ex_ctrl,
    output logic [31:0]      mem_pd,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_rd,
    output logic [4:0]       mem_ctrl
);

    localparam int unsigned CTRL_W  = 14;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RD_W    = 4;
    localparam int unsigned MCTRL_W = 5;

    // Modular increment; carry out is dropped by the PC_W-wide sum.
    always_comb begin
        pc_next = pc_in + PC_W'(PC_INC);
    end

    // Bubble insertion: zero control word neutralises the instruction.
    always_comb begin
        id_ctrl = cu_ctrl;
        if (nop_sel) begin
            id_ctrl = CTRL_W'(0);
        end
    end

    // EX/MEM register: free-running, synchronous clear.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            mem_pd   <= DATA_W'(0);
            mem_addr <= DATA_W'(0);
            mem_rd   <= RD_W'(0);
            mem_ctrl <= MCTRL_W'(0);
        end else begin
            mem_pd   <= ex_pd;
            mem_addr <= ex_alu_res;
            mem_rd   <= ex_rd;
            mem_ctrl <= ex_ctrl;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_ctrl.sv
// Directed bench for ex_mem_stage_ctrl: combinational paths checked directly,
// EX/MEM register checked through an expected-value queue.
module tb_ex_mem_stage_ctrl;

    typedef struct packed {
        logic [31:0] pd;
        logic [31:0] addr;
        logic [3:0]  rd;
        logic [4:0]  ctrl;
    } mem_t;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [7:0]  pc_in;
    logic [7:0]  pc_next;
    logic        nop_sel;
    logic [13:0] cu_ctrl;
    logic [13:0] id_ctrl;
    logic [31:0] ex_pd;
    logic [31:0] ex_alu_res;
    logic [3:0]  ex_rd;
    logic [4:0]  ex_ctrl;
    logic [31:0] mem_pd;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rd;
    logic [4:0]  mem_ctrl;

    int   n_cmp = 0;
    int   n_err = 0;
    mem_t exp_q[$];
    mem_t last;

    ex_mem_stage_ctrl #(.PC_W(8), .PC_INC(4)) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .pc_in      (pc_in),
        .pc_next    (pc_next),
        .nop_sel    (nop_sel),
        .cu_ctrl    (cu_ctrl),
        .id_ctrl    (id_ctrl),
        .ex_pd      (ex_pd),
        .ex_alu_res (ex_alu_res),
        .ex_rd      (ex_rd),
        .ex_ctrl    (ex_ctrl),
        .mem_pd     (mem_pd),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ctrl   (mem_ctrl)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input mem_t e);
        chk({tag, ".pd"},   mem_pd,          e.pd);
        chk({tag, ".addr"}, mem_addr,        e.addr);
        chk({tag, ".rd"},   32'(mem_rd),     32'(e.rd));
        chk({tag, ".ctrl"}, 32'(mem_ctrl),   32'(e.ctrl));
    endtask

    task automatic drive_ex(input logic [31:0] pd, input logic [31:0] addr,
                            input logic [3:0] rd, input logic [4:0] ctrl);
        ex_pd      = pd;
        ex_alu_res = addr;
        ex_rd      = rd;
        ex_ctrl    = ctrl;
    endtask

    // Reference model of what the register holds after the coming edge.
    task automatic push_exp();
        mem_t e;
        if (Clr) e = '{pd: ex_pd, addr: ex_alu_res, rd: ex_rd, ctrl: ex_ctrl};
        else     e = '0;
        exp_q.push_back(e);
    endtask

    task automatic edge_check(input string tag);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            last = exp_q.pop_front();
            chk_mem(tag, last);
        end
    endtask

    task automatic step(input string tag, input logic clr_v, input logic [31:0] pd,
                        input logic [31:0] addr, input logic [3:0] rd, input logic [4:0] ctrl);
        @(negedge Clk);
        Clr = clr_v;
        drive_ex(pd, addr, rd, ctrl);
        push_exp();
        edge_check(tag);
    endtask

    initial begin
        Clr     = 1'b0;
        pc_in   = 8'h00;
        nop_sel = 1'b0;
        cu_ctrl = 14'h0;
        drive_ex(32'h0, 32'h0, 4'h0, 5'h0);

        // Adder vectors including wrap.
        pc_in = 8'h00; #1 chk("pc_00", 32'(pc_next), 32'h04);
        pc_in = 8'h10; #1 chk("pc_10", 32'(pc_next), 32'h14);
        pc_in = 8'hFC; #1 chk("pc_FC", 32'(pc_next), 32'h00);
        pc_in = 8'hFE; #1 chk("pc_FE", 32'(pc_next), 32'h02);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] p;
            logic [7:0] e;
            p = 8'($urandom_range(0, 255));
            e = p + 8'd4;
            pc_in = p;
            #1 chk("pc_rand", 32'(pc_next), 32'(e));
        end

        // Control mux, no clock dependency.
        cu_ctrl = 14'h3FFF; nop_sel = 1'b0; #1 chk("mux_pass", 32'(id_ctrl), 32'h3FFF);
        nop_sel = 1'b1;                   #1 chk("mux_nop", 32'(id_ctrl), 32'h0);
        nop_sel = 1'b0; cu_ctrl = 14'h2A5A; #1 chk("mux_chg", 32'(id_ctrl), 32'h2A5A);

        // Reset overrides all-ones data.
        step("reset", 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 5'b11111);

        // Clr has no influence on the combinational paths.
        pc_in = 8'h10; #1 chk("pc_clr0", 32'(pc_next), 32'h14);
        chk("mux_clr0", 32'(id_ctrl), 32'h2A5A);

        // Load capture, then inputs move mid-cycle while outputs hold.
        step("load", 1'b1, 32'hDEAD_BEEF, 32'h0000_0010, 4'd5, 5'b11000);
        #2 drive_ex(32'h1111_2222, 32'h3333_4444, 4'd9, 5'b00101);
        #1 chk_mem("load_hold", last);
        chk("pc_clr1", 32'(pc_next), 32'h14);

        // Store capture, then Clr dropped between edges.
        step("store", 1'b1, 32'hCAFE_F00D, 32'h0000_0020, 4'd3, 5'b00111);
        #2 Clr = 1'b0;
        #1 chk_mem("store_hold", last);
        push_exp();
        edge_check("store_rst");

        // Clr raised between edges: still zero until the edge, then first capture.
        @(negedge Clk);
        drive_ex(32'hA5A5_5A5A, 32'h0000_0040, 4'd7, 5'b01010);
        Clr = 1'b1;
        #1 chk_mem("release_hold", '0);
        push_exp();
        edge_check("release_cap");

        // Back-to-back words: each appears exactly one edge later.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            drive_ex($urandom, $urandom, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            push_exp();
            @(posedge Clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL pipe observed=empty_queue expected=entry");
            end else begin
                last = exp_q.pop_front();
                chk_mem("pipe", last);
            end
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
